// File: rtl/fetch_sequencer_verilog_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_verilog_if
// Description : Bus bundle for the fetch sequencer. It carries the control
//               inputs (start/stop), the instruction-memory port, the
//               register-stage port and the status outputs.
//               master modport : the sequencer itself
//               slave  modport : the surrounding system (memory, ALU, host)
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_verilog_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  // Host control
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic                  stop;
  // Instruction memory (data returns one cycle after address)
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_data;
  // ALU / register stage
  logic [DATA_WIDTH-1:0] opcode;
  logic [DATA_WIDTH-1:0] operand;
  logic [DATA_WIDTH-1:0] reg_write_data;
  logic                  write_enable;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] reg_read_data;
  logic [3:0]            alu_flags;
  // Results and status
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  busy;
  logic                  halted;
  logic                  illegal;

  modport master (
    input  start, start_addr, stop, imem_data, reg_read_data, alu_flags,
    output imem_addr, opcode, operand, reg_write_data, write_enable,
           read_enable, out_data, out_valid, busy, halted, illegal
  );

  modport slave (
    output start, start_addr, stop, imem_data, reg_read_data, alu_flags,
    input  imem_addr, opcode, operand, reg_write_data, write_enable,
           read_enable, out_data, out_valid, busy, halted, illegal
  );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer_verilog.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_verilog
// Description : Two-word instruction fetch/issue sequencer. Each instruction
//               takes four cycles: FETCH_OP -> FETCH_ARG -> LATCH -> ISSUE.
//               The class in the top nibble of the opcode word selects the
//               strobes issued and the next pc.
// Ports       : clk   - rising-edge clock
//               reset - synchronous, active-high reset
//               bus   - fetch_sequencer_verilog_if.master
//                       start/start_addr/stop : host control
//                       imem_addr/imem_data   : instruction memory
//                       opcode/operand/reg_write_data/write_enable/
//                       read_enable/reg_read_data/alu_flags : register stage
//                       out_data/out_valid/busy/halted/illegal : status
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer_verilog #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input wire clk,
  input wire reset,
  fetch_sequencer_verilog_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH_OP  = 3'd1,
    ST_FETCH_ARG = 3'd2,
    ST_LATCH     = 3'd3,
    ST_ISSUE     = 3'd4,
    ST_HALTED    = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CL_NOP     = 3'd0,
    CL_ALU     = 3'd1,
    CL_LOAD    = 3'd2,
    CL_READ    = 3'd3,
    CL_JUMP    = 3'd4,
    CL_JZ      = 3'd5,
    CL_HALT    = 3'd6,
    CL_ILLEGAL = 3'd7
  } class_e;

  function automatic class_e decode_class(input logic [3:0] field);
    class_e cls;
    case (field)
      4'h0:    cls = CL_NOP;
      4'h1:    cls = CL_ALU;
      4'h2:    cls = CL_LOAD;
      4'h3:    cls = CL_READ;
      4'h4:    cls = CL_JUMP;
      4'h5:    cls = CL_JZ;
      4'hF:    cls = CL_HALT;
      default: cls = CL_ILLEGAL;
    endcase
    return cls;
  endfunction

  state_e                state_q,        state_d;
  logic [ADDR_WIDTH-1:0] pc_q,           pc_d;
  logic [DATA_WIDTH-1:0] op_word_q,      op_word_d;
  logic [DATA_WIDTH-1:0] opcode_q,       opcode_d;
  logic [DATA_WIDTH-1:0] operand_q,      operand_d;
  logic [DATA_WIDTH-1:0] out_data_q,     out_data_d;
  logic                  write_enable_q, write_enable_d;
  logic                  read_enable_q,  read_enable_d;
  logic                  out_valid_q,    out_valid_d;
  logic                  illegal_q,      illegal_d;
  logic                  stop_q,         stop_d;

  logic [ADDR_WIDTH-1:0] pc_plus1;
  logic [ADDR_WIDTH-1:0] pc_plus2;
  logic [ADDR_WIDTH-1:0] jump_target;
  logic                  is_busy;
  class_e                latched_class;
  class_e                issue_class;
  logic                  unused_flags;

  // pc arithmetic wraps naturally at ADDR_WIDTH bits.
  assign pc_plus1    = pc_q + ADDR_WIDTH'(1);
  assign pc_plus2    = pc_q + ADDR_WIDTH'(2);
  assign jump_target = operand_q[ADDR_WIDTH-1:0];
  assign is_busy     = (state_q != ST_IDLE) && (state_q != ST_HALTED);

  // The class lives in the top nibble of the opcode word. The latched word
  // drives the strobes registered on entry to ISSUE; the issued opcode
  // drives the pc/next-state decision inside ISSUE.
  assign latched_class = decode_class(op_word_q[DATA_WIDTH-1 -: 4]);
  assign issue_class   = decode_class(opcode_q[DATA_WIDTH-1 -: 4]);

  // Only the zero flag takes part in sequencing.
  assign unused_flags = ^bus.alu_flags[3:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      pc_q           <= '0;
      op_word_q      <= '0;
      opcode_q       <= '0;
      operand_q      <= '0;
      out_data_q     <= '0;
      write_enable_q <= 1'b0;
      read_enable_q  <= 1'b0;
      out_valid_q    <= 1'b0;
      illegal_q      <= 1'b0;
      stop_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      op_word_q      <= op_word_d;
      opcode_q       <= opcode_d;
      operand_q      <= operand_d;
      out_data_q     <= out_data_d;
      write_enable_q <= write_enable_d;
      read_enable_q  <= read_enable_d;
      out_valid_q    <= out_valid_d;
      illegal_q      <= illegal_d;
      stop_q         <= stop_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    op_word_d      = op_word_q;
    opcode_d       = opcode_q;
    operand_d      = operand_q;
    out_data_d     = out_data_q;
    write_enable_d = 1'b0;
    read_enable_d  = 1'b0;
    out_valid_d    = 1'b0;
    illegal_d      = illegal_q;
    stop_d         = stop_q;

    // A stop request is remembered through the whole instruction.
    if (is_busy && bus.stop) begin
      stop_d = 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (bus.start) begin
          pc_d      = bus.start_addr;
          illegal_d = 1'b0;
          // start wins over a simultaneous stop; the stop is kept so that
          // exactly one instruction runs.
          stop_d    = bus.stop;
          state_d   = ST_FETCH_OP;
        end
      end

      ST_FETCH_OP: begin
        state_d = ST_FETCH_ARG;
      end

      ST_FETCH_ARG: begin
        op_word_d = bus.imem_data;
        state_d   = ST_LATCH;
      end

      ST_LATCH: begin
        // Outputs change only here, so ISSUE sees the new opcode/operand
        // together with its single-cycle strobe.
        opcode_d       = op_word_q;
        operand_d      = bus.imem_data;
        write_enable_d = (latched_class == CL_ALU) || (latched_class == CL_LOAD);
        read_enable_d  = (latched_class == CL_READ);
        state_d        = ST_ISSUE;
      end

      ST_ISSUE: begin
        if (issue_class == CL_READ) begin
          out_data_d  = bus.reg_read_data;
          out_valid_d = 1'b1;
        end
        if (issue_class == CL_ILLEGAL) begin
          illegal_d = 1'b1;
        end

        case (issue_class)
          CL_JUMP: pc_d = jump_target;
          CL_JZ:   pc_d = bus.alu_flags[0] ? jump_target : pc_plus2;
          CL_HALT: pc_d = pc_q;
          default: pc_d = pc_plus2;
        endcase

        stop_d = 1'b0;
        if (issue_class == CL_HALT) begin
          state_d = ST_HALTED;
        end else if (stop_q || bus.stop) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FETCH_OP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.imem_addr      = (state_q == ST_FETCH_ARG) ? pc_plus1 : pc_q;
  assign bus.opcode         = opcode_q;
  assign bus.operand        = operand_q;
  assign bus.reg_write_data = operand_q;
  assign bus.write_enable   = write_enable_q;
  assign bus.read_enable    = read_enable_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.busy           = is_busy;
  assign bus.halted         = (state_q == ST_HALTED);
  assign bus.illegal        = illegal_q;

endmodule
`default_nettype wire

// File: doc/fetch_sequencer_verilog.md
FETCH_SEQUENCER_VERILOG -- requirements
Module: fetch_sequencer_verilog

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the instruction word width and the data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, the instruction memory address width.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  pulse that begins execution at start_addr.
REQ-006 SHALL have port start_addr  input  ADDR_WIDTH  first instruction address.
REQ-007 SHALL have port stop  input  1  request to finish the current instruction and return to IDLE.
REQ-008 SHALL have port imem_addr  output  ADDR_WIDTH  instruction memory address.
REQ-009 SHALL have port imem_data  input  DATA_WIDTH  memory word, valid one cycle after imem_addr.
REQ-010 SHALL have port opcode  output  DATA_WIDTH  registered opcode to the ALU/register stage.
REQ-011 SHALL have port operand  output  DATA_WIDTH  registered operand to the ALU/register stage.
REQ-012 SHALL have port reg_write_data  output  DATA_WIDTH  immediate for LOAD, equal to the operand.
REQ-013 SHALL have port write_enable  output  1  one-cycle register write strobe.
REQ-014 SHALL have port read_enable  output  1  one-cycle register read strobe.
REQ-015 SHALL have port reg_read_data  input  DATA_WIDTH  register read port data.
REQ-016 SHALL have port alu_flags  input  4  ALU flags, where bit0 is zero.
REQ-017 SHALL have port out_data  output  DATA_WIDTH  last value captured by READ.
REQ-018 SHALL have port out_valid  output  1  one-cycle pulse when out_data updates.
REQ-019 SHALL have port busy  output  1  high in any state except IDLE and HALTED.
REQ-020 SHALL have port halted  output  1  high in HALTED.
REQ-021 SHALL have port illegal  output  1  sticky flag, set when an undefined class is issued.

Function
REQ-022 SHALL implement the states IDLE, FETCH_OP, FETCH_ARG, LATCH, ISSUE and HALTED.
REQ-023 SHALL take 4 cycles per instruction in the order FETCH_OP (imem_addr=pc) -> FETCH_ARG (latch the opcode word, imem_addr=pc+1) -> LATCH (latch the operand word) -> ISSUE.
REQ-024 SHALL drive imem_addr=pc in every state other than FETCH_FETCH_ARG, where it drives pc+1.
REQ-025 SHALL, on start in IDLE or HALTED: pc<=start_addr, go to FETCH_OP, clear illegal; ignore start in any other state.
REQ-026 SHALL decode the class from opcode[15:12] as: 0x0 NOP; 0x1 ALU; 0x2 LOAD; 0x3 READ; 0x4 JUMP; 0x5 JZ; 0xF HALT; any other class is illegal.
REQ-027 SHALL update opcode/operand outputs on entry to ISSUE only, and hold them at all other times.
REQ-028 SHALL, in ISSUE for class ALU or LOAD, assert write_enable for exactly that cycle.
REQ-029 SHALL drive reg_write_data equal to the operand output at all times.
REQ-030 SHALL, in ISSUE for class READ, assert read_enable, capture reg_read_data into out_data on that edge, and pulse out_valid in the following cycle.
REQ-031 SHALL compute the next pc in ISSUE as: JUMP -> operand[ADDR_WIDTH-1:0]; JZ -> that target if alu_flags[0]=1, else pc+2; all other classes -> pc+2.
REQ-032 SHALL perform all pc arithmetic modulo 2^ADDR_WIDTH, so pc = 2^ADDR_WIDTH-1 fetches its operand from address 0.
REQ-033 SHALL transition out of ISSUE as: HALT -> HALTED (pc holds HALT address); stop seen since FETCH_OP -> IDLE; else FETCH_OP.
REQ-034 SHALL latch stop when asserted in any busy state; it takes effect only at the end of ISSUE and never truncates an instruction.
REQ-035 SHALL, when start and stop are asserted in the same IDLE cycle, give start priority and latch stop, executing exactly one instruction.
REQ-036 SHALL treat an illegal class as NOP: no strobes, pc+2, illegal<=1.
REQ-037 SHALL never assert write_enable and read_enable together.

Reset
REQ-038 SHALL, on reset at any cycle including mid-instruction, go to IDLE and set pc, imem_addr, opcode, operand, out_data=0 and write_enable, read_enable, out_valid, busy, halted, illegal, stop latch=0.
REQ-039 SHALL not issue any strobe in the cycle following reset.

Verification
REQ-040 SHALL be verified by: LOAD 0x2003/0x00AB at addr 0 -> write_enable high in cycle 4 after start, with opcode 0x2003 and reg_write_data 0x00AB.
REQ-041 SHALL be verified by: ALU 0x1002/0x0100 then READ 0x3002 -> exactly one write_enable, then a read_enable; out_data = reg_read_data; out_valid one cycle later.
REQ-042 SHALL be verified by: JZ 0x5000/0x0010 with alu_flags=0001 -> next imem_addr 0x10; with alu_flags=0000 -> pc+2.
REQ-043 SHALL be verified by: start_addr=0xFF -> operand fetched from 0x00 and the next pc = 0x01.
REQ-044 SHALL be verified by: stop pulsed during FETCH_ARG -> current instruction issues, then IDLE with busy=0; HALT 0xF000 -> halted=1 and start restarts execution.
REQ-045 SHALL be verified by: reset asserted in LATCH -> all outputs 0 next cycle; opcode 0x7000 -> illegal=1, no strobes, execution continues.
